pcm_pingpong_buffer: RTL and testbench

Ping-pong sample buffer between the I2S capture stage and the VU meter. It collects one channel of 24-bit PCM into alternating DEPTH-word banks. It hands each full bank to the consumer with a one-cycle `buffer_ready_o` pulse, then streams the bank out over a ready/valid interface. Lost banks are flagged and counted.

---
 rtl/pcm_pingpong_buffer.sv | 174 +++++++++++++++++
 tb/tb_pcm_pingpong_buffer.sv | 266 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcm_pingpong_buffer.sv
// Ping-pong sample buffer: captures one PCM channel into two alternating
// banks, hands each full bank to the read side with a one-cycle pulse and
// streams it out over ready/valid. Banks completed while the read side is
// still busy are dropped, flagged and counted.
module pcm_pingpong_buffer #(
    parameter int DEPTH       = 16,
    parameter int WIDTH       = 24,
    parameter bit SELECT_LEFT = 1'b1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             sample_stb_i,
    input  logic [WIDTH-1:0] left_sample_i,
    input  logic [WIDTH-1:0] right_sample_i,
    output logic [WIDTH-1:0] read_data_o,
    output logic             read_valid_o,
    input  logic             read_ready_i,
    output logic             buffer_ready_o,
    output logic             overflow_o,
    output logic [15:0]      drop_count_o
);

    localparam int              AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0]   LAST_PTR = AW'(DEPTH - 1);
    localparam logic [15:0]     DROP_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        R_IDLE  = 2'd0,
        R_FETCH = 2'd1,
        R_OUT   = 2'd2
    } rd_state_t;

    // Both banks live in one array; the top address bit selects the bank.
    logic [WIDTH-1:0] r_mem [0:2*DEPTH-1];

    logic [AW-1:0]    r_wr_ptr;
    logic             r_wr_bank;
    logic [AW-1:0]    r_rd_ptr;
    rd_state_t        r_state;
    rd_state_t        w_state_next;
    logic [WIDTH-1:0] r_read_data;
    logic             r_read_valid;
    logic             r_buffer_ready;
    logic             r_overflow;
    logic [15:0]      r_drop_count;

    logic [WIDTH-1:0] w_sample;
    logic             w_rd_hs;
    logic             w_rd_last;
    logic             w_rd_free;
    logic             w_complete;
    logic             w_handover;
    logic             w_drop;

    assign w_sample   = SELECT_LEFT ? left_sample_i : right_sample_i;

    // The read side always owns the bank the writer is not filling.
    assign w_rd_hs    = (r_state == R_OUT) && read_ready_i;
    assign w_rd_last  = (r_rd_ptr == LAST_PTR);
    assign w_rd_free  = (r_state == R_IDLE) || (w_rd_hs && w_rd_last);
    assign w_complete = sample_stb_i && (r_wr_ptr == LAST_PTR);
    assign w_handover = w_complete && w_rd_free;
    assign w_drop     = w_complete && !w_rd_free;

    // Sample storage write port.
    // NOTE: the RAM has no reset so it maps onto block memory; stale contents
    // are harmless because a bank is only read after it has been fully written.
    always_ff @(posedge clk_i) begin
        if (!rst_i && sample_stb_i) begin
            r_mem[{r_wr_bank, r_wr_ptr}] <= w_sample;
        end
    end

    // Read FSM state register.
    // NOTE: all clocked state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= R_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Read FSM next-state logic; a handover coinciding with the final
    // handshake restarts the fetch immediately instead of idling.
    // NOTE: the default assignment first keeps this block free of latches.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            R_IDLE: begin
                if (w_handover) begin
                    w_state_next = R_FETCH;
                end
            end
            R_FETCH: begin
                w_state_next = R_OUT;
            end
            R_OUT: begin
                if (w_rd_hs) begin
                    if (!w_rd_last) begin
                        w_state_next = R_FETCH;
                    end else if (w_handover) begin
                        w_state_next = R_FETCH;
                    end else begin
                        w_state_next = R_IDLE;
                    end
                end
            end
            default: begin
                w_state_next = R_IDLE;
            end
        endcase
    end

    // Write pointer and bank ownership; a dropped bank keeps its bank so the
    // next DEPTH samples overwrite it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_wr_ptr  <= '0;
            r_wr_bank <= 1'b0;
        end else begin
            if (sample_stb_i) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_handover) begin
                r_wr_bank <= ~r_wr_bank;
            end
        end
    end

    // Read pointer, registered read data and registered valid.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_rd_ptr     <= '0;
            r_read_data  <= '0;
            r_read_valid <= 1'b0;
        end else begin
            if (w_handover) begin
                r_rd_ptr <= '0;
            end else if (w_rd_hs && !w_rd_last) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (r_state == R_FETCH) begin
                r_read_data <= r_mem[{~r_wr_bank, r_rd_ptr}];
            end
            r_read_valid <= (w_state_next == R_OUT);
        end
    end

    // Handover pulse and sticky drop bookkeeping.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_buffer_ready <= 1'b0;
            r_overflow     <= 1'b0;
            r_drop_count   <= '0;
        end else begin
            r_buffer_ready <= w_handover;
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (r_drop_count != DROP_MAX) begin
                    r_drop_count <= r_drop_count + 16'd1;
                end
            end
        end
    end

    assign read_data_o    = r_read_data;
    assign read_valid_o   = r_read_valid;
    assign buffer_ready_o = r_buffer_ready;
    assign overflow_o     = r_overflow;
    assign drop_count_o   = r_drop_count;

endmodule

// File: tb/tb_pcm_pingpong_buffer.sv
// Scoreboard bench for pcm_pingpong_buffer. Two instances share stimulus:
// one captures the left channel, the other the right channel.
module tb_pcm_pingpong_buffer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stb = 1'b0;
    logic [23:0] left = '0;
    logic [23:0] right = '0;
    logic        ready = 1'b0;

    logic [23:0] data_l, data_r;
    logic        valid_l, valid_r;
    logic        br_l, br_r;
    logic        ovf_l, ovf_r;
    logic [15:0] drop_l, drop_r;

    int checks = 0;
    int failures = 0;
    int br_count = 0;
    int exp_br = 0;

    logic [23:0] q_l[$];
    logic [23:0] q_r[$];

    always #5 clk = ~clk;

    pcm_pingpong_buffer #(.DEPTH(16), .WIDTH(24), .SELECT_LEFT(1'b1)) dut_l (
        .clk_i(clk), .rst_i(rst), .sample_stb_i(stb),
        .left_sample_i(left), .right_sample_i(right),
        .read_data_o(data_l), .read_valid_o(valid_l), .read_ready_i(ready),
        .buffer_ready_o(br_l), .overflow_o(ovf_l), .drop_count_o(drop_l)
    );

    pcm_pingpong_buffer #(.DEPTH(16), .WIDTH(24), .SELECT_LEFT(1'b0)) dut_r (
        .clk_i(clk), .rst_i(rst), .sample_stb_i(stb),
        .left_sample_i(left), .right_sample_i(right),
        .read_data_o(data_r), .read_valid_o(valid_r), .read_ready_i(ready),
        .buffer_ready_o(br_r), .overflow_o(ovf_r), .drop_count_o(drop_r)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic strobe(input logic [23:0] l, input logic [23:0] r);
        stb   = 1'b1;
        left  = l;
        right = r;
        tick();
        stb   = 1'b0;
    endtask

    task automatic push(input logic [23:0] l, input logic [23:0] r);
        q_l.push_back(l);
        q_r.push_back(r);
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_data_l"}, 32'(data_l), 32'd0);
        check({tag, "_data_r"}, 32'(data_r), 32'd0);
        check({tag, "_valid"}, 32'({valid_l, valid_r}), 32'd0);
        check({tag, "_br"}, 32'({br_l, br_r}), 32'd0);
        check({tag, "_ovf"}, 32'({ovf_l, ovf_r}), 32'd0);
        check({tag, "_drop"}, 32'({drop_l, drop_r}), 32'd0);
    endtask

    // Monitor: pops the scoreboard on every accepted word, counts handover pulses.
    always @(negedge clk) begin
        if (!rst) begin
            if (br_l) br_count++;
            if (valid_l && ready) begin
                if (q_l.size() == 0) begin
                    check("unexpected_word_l", 32'(data_l), 32'hFFFF_FFFF);
                end else begin
                    check("word_l", 32'(data_l), 32'(q_l.pop_front()));
                end
            end
            if (valid_r && ready) begin
                if (q_r.size() == 0) begin
                    check("unexpected_word_r", 32'(data_r), 32'hFFFF_FFFF);
                end else begin
                    check("word_r", 32'(data_r), 32'(q_r.pop_front()));
                end
            end
        end
    end

    initial begin
        #200_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int found;
        int stray;

        // Reset with random inputs for 3 cycles.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            stb   = 1'($urandom);
            left  = 24'($urandom);
            right = 24'($urandom);
            ready = 1'($urandom);
            tick();
            check_zero_outputs("reset");
        end
        stb = 1'b0; left = '0; right = '0; ready = 1'b1;
        rst = 1'b0;

        // Basic bank: samples 1..16, cycle-exact word timing.
        for (int v = 1; v <= 16; v++) begin
            push(24'(v), 24'(v + 24'h100000));
            strobe(24'(v), 24'(v + 24'h100000));
        end
        exp_br++;
        check("basic_br_t1", 32'(br_l), 32'd1);
        check("basic_valid_t1", 32'(valid_l), 32'd0);
        for (int k = 0; k < 16; k++) begin
            tick();
            check("basic_valid_word", 32'(valid_l), 32'd1);
            check("basic_data_word", 32'(data_l), 32'(k + 1));
            check("basic_br_low", 32'(br_l), 32'd0);
            tick();
            check("basic_valid_gap", 32'(valid_l), 32'd0);
        end
        for (int i = 0; i < 4; i++) begin
            tick();
            check("basic_idle_valid", 32'(valid_l), 32'd0);
        end
        check("basic_br_count", 32'(br_count), 32'(exp_br));
        check("basic_q_empty", 32'(q_l.size() + q_r.size()), 32'd0);

        // Backpressure: stall 10 cycles on word 5.
        for (int v = 1; v <= 16; v++) begin
            push(24'(v), 24'(v + 24'h100000));
            strobe(24'(v), 24'(v + 24'h100000));
        end
        exp_br++;
        for (int i = 0; i < 9; i++) tick();
        ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check("bp_valid_held", 32'(valid_l), 32'd1);
            check("bp_data_held", 32'(data_l), 32'd5);
            tick();
        end
        ready = 1'b1;
        for (int i = 0; i < 30; i++) tick();
        check("bp_q_empty", 32'(q_l.size() + q_r.size()), 32'd0);
        check("bp_br_count", 32'(br_count), 32'(exp_br));

        // Overflow: 48 strobes with the consumer stalled.
        ready = 1'b0;
        for (int v = 1; v <= 48; v++) begin
            if (v <= 16) push(24'(v), 24'(v + 24'h100000));
            strobe(24'(v), 24'(v + 24'h100000));
            if (v == 16) begin
                exp_br++;
                check("ovf_br_16", 32'(br_l), 32'd1);
            end
            if (v == 31) check("ovf_flag_before", 32'(ovf_l), 32'd0);
            if (v == 32) begin
                check("ovf_drop_32", 32'(drop_l), 32'd1);
                check("ovf_flag_32", 32'(ovf_l), 32'd1);
                check("ovf_br_32", 32'(br_l), 32'd0);
            end
            if (v == 48) begin
                check("ovf_drop_48_l", 32'(drop_l), 32'd2);
                check("ovf_drop_48_r", 32'(drop_r), 32'd2);
            end
        end
        check("ovf_br_count", 32'(br_count), 32'(exp_br));
        ready = 1'b1;
        for (int i = 0; i < 40; i++) tick();
        check("ovf_drain_empty", 32'(q_l.size() + q_r.size()), 32'd0);
        for (int v = 49; v <= 64; v++) begin
            push(24'(v), 24'(v + 24'h100000));
            strobe(24'(v), 24'(v + 24'h100000));
        end
        exp_br++;
        check("ovf_refill_br", 32'(br_l), 32'd1);
        check("ovf_refill_drop", 32'(drop_l), 32'd2);
        for (int i = 0; i < 40; i++) tick();
        check("ovf_refill_empty", 32'(q_l.size() + q_r.size()), 32'd0);
        check("ovf_refill_br_count", 32'(br_count), 32'(exp_br));

        // Reset between tests.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_zero_outputs("rst2");

        // Simultaneous release: last handshake of bank A with 16th strobe of B.
        ready = 1'b0;
        for (int v = 101; v <= 116; v++) begin
            push(24'(v), 24'(v + 24'h100000));
            strobe(24'(v), 24'(v + 24'h100000));
        end
        exp_br++;
        for (int v = 201; v <= 215; v++) begin
            push(24'(v), 24'(v + 24'h100000));
            strobe(24'(v), 24'(v + 24'h100000));
        end
        push(24'd216, 24'(216 + 24'h100000));
        ready = 1'b1;
        found = 0;
        for (int i = 0; i < 100 && found == 0; i++) begin
            if (valid_l && data_l == 24'd116) found = 1;
            else tick();
        end
        check("sim_wait_last_word", 32'(found), 32'd1);
        strobe(24'd216, 24'(216 + 24'h100000));
        exp_br++;
        check("sim_br", 32'(br_l), 32'd1);
        check("sim_fetch_valid", 32'(valid_l), 32'd0);
        check("sim_drop", 32'(drop_l), 32'd0);
        check("sim_ovf", 32'(ovf_l), 32'd0);
        for (int i = 0; i < 40; i++) tick();
        check("sim_q_empty", 32'(q_l.size() + q_r.size()), 32'd0);
        check("sim_br_count", 32'(br_count), 32'(exp_br));

        // Right channel extremes, then reset during the third word.
        for (int i = 0; i < 16; i++) begin
            logic [23:0] rv;
            logic [23:0] lv;
            lv = 24'h0A0000 + 24'(i);
            if (i == 0) rv = 24'h800000;
            else if (i == 1) rv = 24'hFFFFFF;
            else rv = 24'h000100 + 24'(i);
            if (i < 2) push(lv, rv);
            strobe(lv, rv);
        end
        exp_br++;
        for (int i = 0; i < 5; i++) tick();
        check("mid_valid_word2", 32'(valid_r), 32'd1);
        check("mid_data_r_word2", 32'(data_r), 32'h000102);
        check("mid_data_l_word2", 32'(data_l), 32'h0A0002);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_valid_after_rst", 32'({valid_l, valid_r}), 32'd0);
        check("mid_br_after_rst", 32'({br_l, br_r}), 32'd0);
        stray = 0;
        for (int i = 0; i < 40; i++) begin
            tick();
            if (valid_l || valid_r || br_l || br_r) stray++;
        end
        check("mid_no_stray_activity", 32'(stray), 32'd0);
        check("mid_q_empty", 32'(q_l.size() + q_r.size()), 32'd0);
        check("mid_br_count", 32'(br_count), 32'(exp_br));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
